// File: rtl/cnn1d_pkg.sv
// cnn1d_pkg: shared types and width helpers for the 1D CNN datapath.
package cnn1d_pkg;
    typedef enum logic {PAD_CAUSAL = 1'b0, PAD_VALID = 1'b1} pad_t;
    typedef enum logic [1:0] {IDLE, MAC, FIN, OUT} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int fs);
        return 2 * dw + clog2(fs);
    endfunction
endpackage

// File: rtl/sat_relu.sv
// sat_relu: saturate a wide signed value to OUT_W bits, then optionally clamp negatives to 0.
module sat_relu #(
    parameter int IN_W    = 28,
    parameter int OUT_W   = 12,
    parameter int RELU_EN = 1
) (
    input  logic signed [IN_W-1:0] value,
    output logic [OUT_W-1:0]       result
);
    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

    logic [OUT_W-1:0] sat;

    always_comb begin
        sat = value > MAX_V ? MAX_V[OUT_W-1:0] : value < MIN_V ? MIN_V[OUT_W-1:0] : value[OUT_W-1:0];
        result = (RELU_EN != 0) && sat[OUT_W-1] ? '0 : sat;
    end
endmodule

// File: rtl/conv1d_par.sv
// conv1d_par: streaming 1D convolution with NUM_MULTS multipliers per beat, stride,
// causal/valid padding, frame restart, saturation and optional ReLU.
module conv1d_par
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH  = 12,
    parameter int FRACTION    = 0,
    parameter int FILTER_SIZE = 5,
    parameter int NUM_MULTS   = 1,
    parameter int STRIDE      = 1,
    parameter int PADDING     = 0,
    parameter int RELU_EN     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  conv1d_ready_in,
    input  logic                  conv1d_valid_in,
    input  logic [DATA_WIDTH-1:0] conv1d_data_in,
    input  logic                  conv1d_last_in,
    input  logic [DATA_WIDTH-1:0] conv1d_weights [0:FILTER_SIZE-1],
    input  logic [DATA_WIDTH-1:0] conv1d_bias,
    input  logic                  conv1d_ready_out,
    output logic                  conv1d_valid_out,
    output logic [DATA_WIDTH-1:0] conv1d_data_out
);
    localparam int AW    = acc_width(DATA_WIDTH, FILTER_SIZE);
    localparam int BEATS = (FILTER_SIZE + NUM_MULTS - 1) / NUM_MULTS;
    localparam int BW    = clog2(BEATS) + 1;
    localparam int CW    = clog2(FILTER_SIZE) + 1;
    localparam int PW    = clog2(STRIDE) + 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] win     [0:FILTER_SIZE-1];
    logic [DATA_WIDTH-1:0] snap    [0:FILTER_SIZE-1];
    logic [DATA_WIDTH-1:0] shifted [0:FILTER_SIZE-1];
    logic [DATA_WIDTH-1:0] xs, ws, result;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         phase;
    logic [BW-1:0]         beat;
    logic signed [AW-1:0]  acc, beat_sum, biased;
    logic                  accept, full, trigger;

    assign conv1d_ready_in = state == IDLE;
    assign accept  = conv1d_valid_in && conv1d_ready_in;
    // cnt saturates once the window is full; phase tracks stride only from then on
    assign full    = PADDING == int'(PAD_VALID) ? int'(cnt) + 1 >= FILTER_SIZE : 1'b1;
    assign trigger = full && phase == '0;

    always_comb begin
        shifted[0] = conv1d_data_in;
        for (int k = 1; k < FILTER_SIZE; k++) shifted[k] = win[k-1];
    end

    // each multiplier picks its tap for this beat; taps past the filter contribute 0
    always_comb begin
        beat_sum = '0;
        xs = '0;
        ws = '0;
        for (int j = 0; j < NUM_MULTS; j++) begin
            xs = '0;
            ws = '0;
            for (int t = 0; t < FILTER_SIZE; t++)
                if (int'(beat) * NUM_MULTS + j == t) begin
                    xs = snap[t];
                    ws = conv1d_weights[t];
                end
            beat_sum = beat_sum + AW'($signed(ws)) * AW'($signed(xs));
        end
    end

    assign biased = (acc + (AW'($signed(conv1d_bias)) <<< FRACTION)) >>> FRACTION;

    sat_relu #(.IN_W(AW), .OUT_W(DATA_WIDTH), .RELU_EN(RELU_EN)) u_sat (
        .value  (biased),
        .result (result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            phase            <= '0;
            beat             <= '0;
            acc              <= '0;
            conv1d_valid_out <= 1'b0;
            conv1d_data_out  <= '0;
            for (int k = 0; k < FILTER_SIZE; k++) begin
                win[k]  <= '0;
                snap[k] <= '0;
            end
        end else begin
            if (accept) begin
                snap  <= shifted;
                for (int k = 0; k < FILTER_SIZE; k++) win[k] <= conv1d_last_in ? '0 : shifted[k];
                cnt   <= conv1d_last_in ? '0 : full ? cnt : cnt + 1'b1;
                phase <= conv1d_last_in || (full && int'(phase) == STRIDE - 1) ? '0 : full ? phase + 1'b1 : phase;
            end
            unique case (state)
                IDLE: if (accept && trigger) begin
                    state <= MAC;
                    acc   <= '0;
                    beat  <= '0;
                end
                MAC: begin
                    acc   <= acc + beat_sum;
                    beat  <= beat + 1'b1;
                    state <= int'(beat) == BEATS - 1 ? FIN : MAC;
                end
                FIN: begin
                    conv1d_data_out  <= result;
                    conv1d_valid_out <= 1'b1;
                    state            <= OUT;
                end
                OUT: if (conv1d_ready_out) begin
                    conv1d_valid_out <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv1d_par.sv
// tb_conv1d_par: scoreboard bench for conv1d_par across causal, valid-stride and ReLU builds.
module tb_conv1d_par;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vin = 1'b0, lst = 1'b0, rout = 1'b1;
    logic [11:0] din = '0, bias = '0;
    logic [11:0] w [0:4];
    logic [1:0]  sel = 2'd0;
    logic        rdy [0:2];
    logic        vo  [0:2];
    logic [11:0] dq  [0:2];
    logic        rdy_m, vo_m;
    logic [11:0] dout_m;
    int          checks = 0, errors = 0, cyc = 0;
    logic [11:0] exp_q [$];
    int          acc_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdy_m  = rdy[sel];
    assign vo_m   = vo[sel];
    assign dout_m = dq[sel];

    conv1d_par #(.DATA_WIDTH(12), .FRACTION(0), .FILTER_SIZE(5), .NUM_MULTS(2), .STRIDE(1), .PADDING(0), .RELU_EN(0)) u_causal (
        .clk(clk), .rst(rst), .conv1d_ready_in(rdy[0]), .conv1d_valid_in(vin && sel == 2'd0),
        .conv1d_data_in(din), .conv1d_last_in(lst), .conv1d_weights(w), .conv1d_bias(bias),
        .conv1d_ready_out(rout), .conv1d_valid_out(vo[0]), .conv1d_data_out(dq[0]));

    conv1d_par #(.DATA_WIDTH(12), .FRACTION(0), .FILTER_SIZE(5), .NUM_MULTS(2), .STRIDE(2), .PADDING(1), .RELU_EN(0)) u_valid (
        .clk(clk), .rst(rst), .conv1d_ready_in(rdy[1]), .conv1d_valid_in(vin && sel == 2'd1),
        .conv1d_data_in(din), .conv1d_last_in(lst), .conv1d_weights(w), .conv1d_bias(bias),
        .conv1d_ready_out(rout), .conv1d_valid_out(vo[1]), .conv1d_data_out(dq[1]));

    conv1d_par #(.DATA_WIDTH(12), .FRACTION(0), .FILTER_SIZE(5), .NUM_MULTS(2), .STRIDE(1), .PADDING(0), .RELU_EN(1)) u_relu (
        .clk(clk), .rst(rst), .conv1d_ready_in(rdy[2]), .conv1d_valid_in(vin && sel == 2'd2),
        .conv1d_data_in(din), .conv1d_last_in(lst), .conv1d_weights(w), .conv1d_bias(bias),
        .conv1d_ready_out(rout), .conv1d_valid_out(vo[2]), .conv1d_data_out(dq[2]));

    task automatic do_reset();
        vin = 1'b0;
        lst = 1'b0;
        rout = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic set_weights(input logic [11:0] v, input logic [11:0] b);
        for (int k = 0; k < 5; k++) w[k] = v;
        bias = b;
    endtask

    // drive one sample at a negedge; expected result (if any) goes to the scoreboard
    task automatic send(input logic [11:0] d, input bit l, input bit has, input logic [11:0] e);
        int n;
        n = 0;
        din = d;
        lst = l;
        vin = 1'b1;
        while (!rdy_m && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ready_in=%0b required 1", rdy_m);
        end
        if (has) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        vin = 1'b0;
        lst = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy[2'(i)] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got %b want 1", i, rdy[2'(i)]); end
            checks++;
            if (vo[2'(i)] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got %b want 0", i, vo[2'(i)]); end
            checks++;
            if (dq[2'(i)] !== 12'd0) begin errors++; $display("FAIL reset_data[%0d] got %h want 000", i, dq[2'(i)]); end
        end
    endtask

    task automatic test_causal();
        logic [11:0] c_exp [6] = '{12'd1, 12'd3, 12'd6, 12'd10, 12'd15, 12'd20};
        logic [11:0] e;
        int n, a;
        do_reset();
        sel = 2'd0;
        set_weights(12'd1, 12'd0);
        fork
            for (int i = 0; i < 6; i++) send(12'(i + 1), 1'b0, 1'b1, c_exp[i]);
            for (int i = 0; i < 6; i++) begin
                n = 0;
                while (!vo_m && n < 50) begin @(negedge clk); n++; end
                e = exp_q.size() > 0 ? exp_q.pop_front() : 12'hxxx;
                a = acc_q.size() > 0 ? acc_q.pop_front() : -100;
                checks++;
                if (!vo_m || dout_m !== e) begin errors++; $display("FAIL causal_out[%0d] got %0d valid %b want %0d", i, dout_m, vo_m, e); end
                checks++;
                if (cyc - a != 4) begin errors++; $display("FAIL causal_latency[%0d] got %0d want 4", i, cyc - a); end
                @(negedge clk);
            end
        join
    endtask

    task automatic test_valid();
        logic [11:0] e;
        int n, t0;
        do_reset();
        sel = 2'd1;
        set_weights(12'd1, 12'd0);
        fork
            begin
                t0 = cyc;
                for (int i = 1; i <= 4; i++) send(12'(i), 1'b0, 1'b0, 12'd0);
                checks++;
                if (cyc - t0 != 4) begin errors++; $display("FAIL valid_stream_cycles got %0d want 4", cyc - t0); end
                for (int i = 5; i <= 9; i++) send(12'(i), 1'b0, i % 2 == 1, 12'(5 * i - 10));
            end
            for (int i = 0; i < 3; i++) begin
                n = 0;
                while (!vo_m && n < 80) begin @(negedge clk); n++; end
                e = exp_q.size() > 0 ? exp_q.pop_front() : 12'hxxx;
                checks++;
                if (!vo_m || dout_m !== e) begin errors++; $display("FAIL valid_out[%0d] got %0d valid %b want %0d", i, dout_m, vo_m, e); end
                @(negedge clk);
            end
        join
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n += int'(vo_m);
        end
        checks++;
        if (n != 0 || exp_q.size() != 0) begin errors++; $display("FAIL valid_no_extra got %0d extra cycles, %0d pending want 0", n, exp_q.size()); end
    endtask

    task automatic test_saturation();
        logic [1:0]  c_sel [5] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0};
        logic [11:0] c_w   [5] = '{12'd2047, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
        logic [11:0] c_b   [5] = '{12'd0, 12'h800, 12'h800, 12'd0, 12'd0};
        logic [11:0] c_in  [5] = '{12'd2047, 12'd5, 12'd5, 12'd5, 12'd5};
        logic [11:0] c_exp [5] = '{12'd2047, 12'h800, 12'd0, 12'd0, 12'hFFB};
        logic [11:0] e;
        int n;
        for (int i = 0; i < 5; i++) begin
            do_reset();
            sel = c_sel[i];
            set_weights(c_w[i], c_b[i]);
            send(c_in[i], 1'b0, 1'b1, c_exp[i]);
            n = 0;
            while (!vo_m && n < 50) begin @(negedge clk); n++; end
            e = exp_q.size() > 0 ? exp_q.pop_front() : 12'hxxx;
            checks++;
            if (!vo_m || dout_m !== e) begin errors++; $display("FAIL sat_case[%0d] got %0d valid %b want %0d", i, $signed(dout_m), vo_m, $signed(e)); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] c_exp [6] = '{12'd1, 12'd3, 12'd6, 12'd10, 12'd15, 12'd20};
        logic [11:0] e;
        int n;
        do_reset();
        sel = 2'd0;
        set_weights(12'd1, 12'd0);
        fork
            for (int i = 0; i < 6; i++) send(12'(i + 1), 1'b0, 1'b1, c_exp[i]);
            for (int i = 0; i < 6; i++) begin
                n = 0;
                while (!vo_m && n < 50) begin @(negedge clk); n++; end
                if (i == 0) begin
                    rout = 1'b0;
                    repeat (10) begin
                        @(negedge clk);
                        checks++;
                        if (vo_m !== 1'b1 || dout_m !== 12'd1 || rdy_m !== 1'b0) begin
                            errors++;
                            $display("FAIL bp_hold got valid %b data %0d ready_in %b want 1 1 0", vo_m, dout_m, rdy_m);
                        end
                    end
                    rout = 1'b1;
                end
                e = exp_q.size() > 0 ? exp_q.pop_front() : 12'hxxx;
                checks++;
                if (!vo_m || dout_m !== e) begin errors++; $display("FAIL bp_out[%0d] got %0d valid %b want %0d", i, dout_m, vo_m, e); end
                @(negedge clk);
            end
        join
    endtask

    task automatic test_frame_restart();
        logic [11:0] c_in  [5] = '{12'd1, 12'd2, 12'd3, 12'd4, 12'd5};
        logic [11:0] c_exp [5] = '{12'd1, 12'd3, 12'd6, 12'd4, 12'd9};
        logic [11:0] e;
        int n;
        do_reset();
        sel = 2'd0;
        set_weights(12'd1, 12'd0);
        fork
            for (int i = 0; i < 5; i++) send(c_in[i], i == 2, 1'b1, c_exp[i]);
            for (int i = 0; i < 5; i++) begin
                n = 0;
                while (!vo_m && n < 50) begin @(negedge clk); n++; end
                e = exp_q.size() > 0 ? exp_q.pop_front() : 12'hxxx;
                checks++;
                if (!vo_m || dout_m !== e) begin errors++; $display("FAIL restart_out[%0d] got %0d valid %b want %0d", i, dout_m, vo_m, e); end
                @(negedge clk);
            end
        join
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        int n;
        do_reset();
        sel = 2'd0;
        set_weights(12'd1, 12'd0);
        rout = 1'b0;
        send(12'd5, 1'b0, 1'b0, 12'd0);
        n = 0;
        while (!vo_m && n < 50) begin @(negedge clk); n++; end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (vo_m !== 1'b0 || rdy_m !== 1'b1 || dout_m !== 12'd0) begin
            errors++;
            $display("FAIL areset_out got valid %b ready_in %b data %0d want 0 1 0", vo_m, rdy_m, dout_m);
        end
        @(negedge clk);
        rst = 1'b1;
        rout = 1'b1;
        send(12'd5, 1'b0, 1'b0, 12'd0);
        checks++;
        if (rdy_m !== 1'b0) begin errors++; $display("FAIL areset_in_mac ready_in got %b want 0", rdy_m); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (vo_m !== 1'b0 || rdy_m !== 1'b1) begin errors++; $display("FAIL areset_mac got valid %b ready_in %b want 0 1", vo_m, rdy_m); end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        send(12'd7, 1'b0, 1'b1, 12'd7);
        n = 0;
        while (!vo_m && n < 50) begin @(negedge clk); n++; end
        e = exp_q.size() > 0 ? exp_q.pop_front() : 12'hxxx;
        checks++;
        if (!vo_m || dout_m !== e) begin errors++; $display("FAIL areset_after got %0d valid %b want %0d", dout_m, vo_m, e); end
        @(negedge clk);
    endtask

    initial begin
        set_weights(12'd1, 12'd0);
        test_reset();
        test_causal();
        test_valid();
        test_saturation();
        test_back_to_back();
        test_frame_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/conv1d_par.md
# conv1d_par

Parametrised successor to the single-multiplier causal convolution core. It convolves a sequential signed fixed-point stream with a FILTER_SIZE-tap kernel using NUM_MULTS parallel multipliers, and supports configurable stride, causal or valid padding, frame restart, output saturation and optional ReLU. It sits between AXI-style stream producers and consumers in the 1D CNN datapath and replaces the conv1d/relu pair where throughput or framing is needed.

## Interface
- DATA_WIDTH, 12: sample, weight, bias and output width; signed two's complement.
- FRACTION, 0: fractional bits of every DATA_WIDTH quantity.
- FILTER_SIZE, 5: number of taps, at least 1.
- NUM_MULTS, 1: parallel multipliers, 1..FILTER_SIZE.
- STRIDE, 1: samples between outputs, at least 1.
- PADDING, 0: 0 = causal (zero-filled window), 1 = valid (no output until the window is full).
- RELU_EN, 1: 1 = clamp negative results to 0.
- clk, input, 1: sole clock.
- rst, input, 1: reset, asynchronous, active-low.
- conv1d_ready_in, output, 1: block accepts a sample.
- conv1d_valid_in, input, 1: sample valid.
- conv1d_data_in, input, DATA_WIDTH: sample.
- conv1d_last_in, input, 1: sample is the last of its frame.
- conv1d_weights, input, DATA_WIDTH x [0:FILTER_SIZE-1]: static weights.
- conv1d_bias, input, DATA_WIDTH: static bias.
- conv1d_ready_out, input, 1: consumer ready.
- conv1d_valid_out, output, 1: result valid.
- conv1d_data_out, output, DATA_WIDTH: result.

## Operation
- Window: win[0] is the newest sample. On each accepted sample, win shifts up and win[0] takes data_in. Output = sum over k of weights[k]*win[k], plus bias.
- Sample counter cnt counts accepted samples in the current frame.
  - Output trigger in causal mode: (cnt mod STRIDE)==0, with cnt taken before the increment.
  - Output trigger in valid mode: cnt+1 >= FILTER_SIZE and (cnt+1-FILTER_SIZE) mod STRIDE == 0.
- An accepted sample without a trigger leaves the FSM in IDLE.
- Frame restart: the window update and compute use the last sample normally. After that, win clears to 0 and cnt clears to 0, both taking effect on the accepting edge for subsequent samples. The current compute uses a snapshot.
- FSM:
  - IDLE: ready_in=1. A triggering accept goes to MAC and clears the accumulator.
  - MAC: runs for B = ceil(FILTER_SIZE/NUM_MULTS) beats. Beat b adds products for taps b*NUM_MULTS .. b*NUM_MULTS+NUM_MULTS-1; taps at or beyond FILTER_SIZE contribute 0. The last beat goes to FIN.
  - FIN: computes the result and loads data_out; valid_out becomes 1; go to OUT.
  - OUT: holds until ready_out, then returns to IDLE.
- ready_in is 0 in MAC, FIN and OUT.
- Arithmetic:
  - Accumulator width is 2*DATA_WIDTH + clog2(FILTER_SIZE), signed.
  - FIN adds bias sign-extended and shifted left by FRACTION, then arithmetic-shifts right by FRACTION.
  - The result saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then ReLU is applied if RELU_EN.
- Weights and bias are sampled every beat; they must not change while not in IDLE.

## Timing
- Reset values: ready_in=1, valid_out=0, data_out=0. Also win=0, cnt=0, state=IDLE.
- Asserting reset at any point, including mid-MAC or in OUT, drops valid_out immediately and discards any pending result.
- Latency: a trigger accepted at edge t gives valid_out high after edge t+B+1.
- Throughput: at most one output per B+3 cycles (t accept, B beats, FIN, OUT handshake, IDLE).
- In OUT, data_out and valid_out are stable until the handshake. Back-pressure never loses or duplicates a result.
- A sample is consumed only when valid_in and ready_in are both high. Non-triggering samples stream at 1 per cycle.

## Structure
- The package cnn1d_pkg gains:
  - clog2;
  - a padding-mode enum (PAD_CAUSAL, PAD_VALID);
  - a state enum (IDLE, MAC, FIN, OUT);
  - an accumulator-width function.
- Sub-module sat_relu, combinational: takes the shifted accumulator, saturates it and applies optional ReLU. It is reusable by other layers.
- Multipliers are inferred signed products; there are no vendor IP instances.

## Test plan
Common config for every scenario: DATA_WIDTH=12, FRACTION=0, FILTER_SIZE=5, NUM_MULTS=2 (B=3), weights all 1, bias 0, RELU_EN=0, unless stated.
- Causal, STRIDE=1, inputs 1,2,3,4,5,6 -> outputs 1,3,6,10,15,20; each output arrives 4 cycles after its accept.
- Valid, STRIDE=2, inputs 1..9 -> outputs 15,25,35 only (after samples 5, 7 and 9); samples 1-4 produce nothing.
- Saturation: weights 2047, inputs 2047 -> 2047. Weights -1 with bias -2048 -> -2048. Same case with RELU_EN=1 -> 0.
- Back-pressure: hold ready_out=0 for 10 cycles on the first output -> valid_out and data_out stay stable and ready_in=0 throughout. After release, all 6 outputs of scenario 1 arrive in order.
- Frame restart, causal, inputs 1,2,3(last),4,5 -> 1,3,6,4,9.
- Async reset asserted during MAC -> valid_out=0 and ready_in=1 with no clock edge. After release, input 7 -> output 7.
